// File: rtl/led_display_pattern_gen.sv
// Test-pattern source for a 64x32 HUB75-style panel: one top+bottom RGB row pair per transfer.
// Latency: row_out and row_valid_out are combinational from registered mode/effect state and row_ready_in.
// Backpressure: a row is offered only while row_ready_in is high, so every valid cycle is a transfer; state holds otherwise.
module led_display_pattern_gen #(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter bit SIMULATION     = 1'b0,
  parameter int NUM_COL_PIXELS = 64
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic [3:0]                    mode_in,
  output logic [6*NUM_COL_PIXELS-1:0]   row_out,
  output logic                          row_valid_out,
  input  logic                          row_ready_in,
  output logic [3:0]                    row_address_out
);

  localparam logic [3:0] MODE_OFF   = 4'd0;
  localparam logic [3:0] MODE_RED   = 4'd1;
  localparam logic [3:0] MODE_GREEN = 4'd2;
  localparam logic [3:0] MODE_BLUE  = 4'd3;
  localparam logic [3:0] MODE_RG    = 4'd4;
  localparam logic [3:0] MODE_GB    = 4'd5;
  localparam logic [3:0] MODE_RB    = 4'd6;
  localparam logic [3:0] MODE_WHITE = 4'd7;
  localparam logic [3:0] MODE_SCAN  = 4'd8;
  localparam logic [3:0] MODE_PULSE = 4'd9;

  // Pulse duty advances once per millisecond of system clock (or a fixed short period in simulation).
  localparam int STEP   = SIMULATION ? 1000 : SYS_CLK_FREQ / 1000;
  localparam int STEP_W = $clog2(STEP + 1);
  localparam int COL_W  = (NUM_COL_PIXELS > 1) ? $clog2(NUM_COL_PIXELS) : 1;

  typedef struct packed {
    logic [NUM_COL_PIXELS-1:0] red;
    logic [NUM_COL_PIXELS-1:0] green;
    logic [NUM_COL_PIXELS-1:0] blue;
  } rgb_half_t;

  typedef struct packed {
    rgb_half_t top;
    rgb_half_t bot;
  } rgb_row_t;

  typedef enum logic {
    RAMP_UP,
    RAMP_DOWN
  } ramp_t;

  logic [3:0]        mode_q;
  logic [3:0]        addr_q;
  logic [COL_W-1:0]  col_q;
  logic [7:0]        pwm_cnt;
  logic [7:0]        duty_q;
  logic [7:0]        duty_d;
  logic [STEP_W-1:0] step_cnt;
  ramp_t             ramp_q;
  ramp_t             ramp_d;

  logic                      mode_change;
  logic                      transfer;
  logic                      step_tick;
  logic                      pwm_on;
  logic [NUM_COL_PIXELS-1:0] scan_bit;
  rgb_half_t                 half;
  rgb_row_t                  row;

  assign mode_change = (mode_in != mode_q);
  // Reset gating keeps a row from being offered while state is being cleared.
  assign row_valid_out   = row_ready_in & ~mode_change & ~reset_in;
  assign transfer        = row_valid_out & row_ready_in;
  assign row_address_out = mode_change ? 4'd0 : addr_q;
  assign step_tick       = (step_cnt == STEP_W'(STEP - 1));
  assign pwm_on          = (pwm_cnt < duty_q);
  assign scan_bit        = {{(NUM_COL_PIXELS-1){1'b0}}, 1'b1} << col_q;

  // Mode register, row address and scan column; a mode change restarts the row and scan sequence.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      mode_q <= MODE_OFF;
      addr_q <= 4'd0;
      col_q  <= '0;
    end else if (mode_change) begin
      mode_q <= mode_in;
      addr_q <= 4'd0;
      col_q  <= '0;
    end else if (transfer) begin
      addr_q <= addr_q + 4'd1;
      if (mode_q == MODE_SCAN) begin
        col_q <= (col_q == COL_W'(NUM_COL_PIXELS - 1)) ? '0 : col_q + COL_W'(1);
      end
    end
  end

  // Pulse timebase: free-running PWM phase, step prescaler, and triangle duty; untouched by mode changes.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pwm_cnt  <= 8'd0;
      step_cnt <= '0;
      duty_q   <= 8'd0;
      ramp_q   <= RAMP_UP;
    end else begin
      pwm_cnt  <= pwm_cnt + 8'd1;
      step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
      duty_q   <= duty_d;
      ramp_q   <= ramp_d;
    end
  end

  // Triangle ramp: turn around at the extremes so 255 and 0 are each held for a single step.
  always_comb begin
    duty_d = duty_q;
    ramp_d = ramp_q;
    if (step_tick) begin
      case (ramp_q)
        RAMP_UP: begin
          if (duty_q == 8'd255) begin
            ramp_d = RAMP_DOWN;
            duty_d = 8'd254;
          end else begin
            duty_d = duty_q + 8'd1;
          end
        end
        RAMP_DOWN: begin
          if (duty_q == 8'd0) begin
            ramp_d = RAMP_UP;
            duty_d = 8'd1;
          end else begin
            duty_d = duty_q - 8'd1;
          end
        end
        default: begin
          ramp_d = RAMP_UP;
          duty_d = 8'd0;
        end
      endcase
    end
  end

  // Row content: both panel halves carry the same pattern, chosen by the registered mode.
  always_comb begin
    half = '0;
    case (mode_q)
      MODE_RED:   half.red = '1;
      MODE_GREEN: half.green = '1;
      MODE_BLUE:  half.blue = '1;
      MODE_RG: begin
        half.red   = '1;
        half.green = '1;
      end
      MODE_GB: begin
        half.green = '1;
        half.blue  = '1;
      end
      MODE_RB: begin
        half.red  = '1;
        half.blue = '1;
      end
      MODE_WHITE: half = '1;
      MODE_SCAN:  half.red = scan_bit;
      MODE_PULSE: half = {(3*NUM_COL_PIXELS){pwm_on}};
      default:    half = '0;
    endcase
    row.top = half;
    row.bot = half;
    row_out = row;
  end

endmodule

// File: tb/tb_led_display_pattern_gen.sv
// Directed bench for led_display_pattern_gen: colour modes, handshake, mode-change forcing, scan walk, pulse PWM, reset.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// A failed check reports via $error and the run still reaches the summary line.
module tb_led_display_pattern_gen;

  logic         clk_in = 1'b0;
  logic         reset_in;
  logic [3:0]   mode_in;
  logic [383:0] row_out;
  logic         row_valid_out;
  logic         row_ready_in;
  logic [3:0]   row_address_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  led_display_pattern_gen #(
    .SYS_CLK_FREQ(100_000_000),
    .SIMULATION(1'b1),
    .NUM_COL_PIXELS(64)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .mode_in(mode_in),
    .row_out(row_out),
    .row_valid_out(row_valid_out),
    .row_ready_in(row_ready_in),
    .row_address_out(row_address_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [383:0] observed, input logic [383:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [383:0] color_row(input logic r, input logic g, input logic b);
    return {{64{r}}, {64{g}}, {64{b}}, {64{r}}, {64{g}}, {64{b}}};
  endfunction

  function automatic logic [383:0] mode_row(input int m);
    case (m)
      1:       return color_row(1'b1, 1'b0, 1'b0);
      2:       return color_row(1'b0, 1'b1, 1'b0);
      3:       return color_row(1'b0, 1'b0, 1'b1);
      4:       return color_row(1'b1, 1'b1, 1'b0);
      5:       return color_row(1'b0, 1'b1, 1'b1);
      6:       return color_row(1'b1, 1'b0, 1'b1);
      7:       return color_row(1'b1, 1'b1, 1'b1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [383:0] scan_row(input int c);
    logic [63:0] oh;
    oh = 64'd1 << c;
    return {oh, 128'd0, oh, 128'd0};
  endfunction

  initial begin
    logic rdy;
    int   ea;
    int   guard;
    int   on_cnt;
    logic mixed;

    // Reset state, with ready high to show valid stays low during reset.
    reset_in = 1'b1;
    mode_in = 4'd0;
    row_ready_in = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk_in);
    check("reset_row", row_out, '0);
    check("reset_valid", 384'(row_valid_out), 384'(0));
    check("reset_addr", 384'(row_address_out), 384'(0));
    next_cycle();

    // Mode 1, ready held: one mode-change cycle, then a row every cycle.
    reset_in = 1'b0;
    mode_in = 4'd1;
    @(negedge clk_in);
    check("red_chg_valid", 384'(row_valid_out), 384'(0));
    check("red_chg_addr", 384'(row_address_out), 384'(0));
    next_cycle();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk_in);
      check("red_valid", 384'(row_valid_out), 384'(1));
      check("red_addr", 384'(row_address_out), 384'(i % 16));
      check("red_row", row_out, color_row(1'b1, 1'b0, 1'b0));
      next_cycle();
    end

    // Modes 0..7 with ready toggling every cycle.
    rdy = 1'b0;
    for (int m = 0; m < 8; m++) begin
      mode_in = 4'(m);
      row_ready_in = rdy;
      @(negedge clk_in);
      check("mode_chg_valid", 384'(row_valid_out), 384'(0));
      check("mode_chg_addr", 384'(row_address_out), 384'(0));
      next_cycle();
      rdy = ~rdy;
      ea = 0;
      for (int j = 0; j < 6; j++) begin
        row_ready_in = rdy;
        @(negedge clk_in);
        check("mode_valid", 384'(row_valid_out), 384'(rdy));
        check("mode_addr", 384'(row_address_out), 384'(ea));
        check("mode_row", row_out, mode_row(m));
        if (rdy) ea++;
        next_cycle();
        rdy = ~rdy;
      end
    end

    // Mode 6 up to address 9, then switch to mode 2 within that cycle.
    mode_in = 4'd6;
    row_ready_in = 1'b1;
    @(negedge clk_in);
    check("m6_chg_valid", 384'(row_valid_out), 384'(0));
    next_cycle();
    for (int j = 0; j < 9; j++) begin
      @(negedge clk_in);
      check("m6_addr", 384'(row_address_out), 384'(j));
      next_cycle();
    end
    row_ready_in = 1'b0;
    @(negedge clk_in);
    check("m6_addr_hold9", 384'(row_address_out), 384'(9));
    check("m6_hold_row", row_out, mode_row(6));
    #1;
    mode_in = 4'd2;
    row_ready_in = 1'b1;
    #1;
    check("m2_force_addr", 384'(row_address_out), 384'(0));
    check("m2_force_valid", 384'(row_valid_out), 384'(0));
    next_cycle();
    @(negedge clk_in);
    check("m2_first_valid", 384'(row_valid_out), 384'(1));
    check("m2_first_addr", 384'(row_address_out), 384'(0));
    check("m2_first_row", row_out, color_row(1'b0, 1'b1, 1'b0));
    next_cycle();

    // Scan: the red one-hot walks all 64 columns and wraps.
    mode_in = 4'd8;
    @(negedge clk_in);
    check("scan_chg_valid", 384'(row_valid_out), 384'(0));
    next_cycle();
    for (int i = 0; i < 70; i++) begin
      @(negedge clk_in);
      check("scan_valid", 384'(row_valid_out), 384'(1));
      check("scan_addr", 384'(row_address_out), 384'(i % 16));
      check("scan_row", row_out, scan_row(i % 64));
      next_cycle();
    end

    // Ready low: no rows, address and column hold.
    row_ready_in = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk_in);
      check("hold_valid", 384'(row_valid_out), 384'(0));
      check("hold_addr", 384'(row_address_out), 384'(6));
      check("hold_row", row_out, scan_row(6));
      next_cycle();
    end
    row_ready_in = 1'b1;
    @(negedge clk_in);
    check("resume_valid", 384'(row_valid_out), 384'(1));
    check("resume_row", row_out, scan_row(6));
    next_cycle();
    @(negedge clk_in);
    check("resume_addr", 384'(row_address_out), 384'(7));
    check("resume_row_next", row_out, scan_row(7));

    // Reset mid-cycle clears outputs without waiting for a clock edge.
    #2;
    reset_in = 1'b1;
    #1;
    check("async_rst_row", row_out, '0);
    check("async_rst_valid", 384'(row_valid_out), 384'(0));
    check("async_rst_addr", 384'(row_address_out), 384'(0));

    // Pulse: with a 1000-cycle step, duty equals k during cycles k*1000..k*1000+999,
    // and any 256 consecutive cycles there hold exactly k lit cycles.
    mode_in = 4'd9;
    row_ready_in = 1'b1;
    next_cycle();
    next_cycle();
    reset_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      guard = 0;
      @(negedge clk_in);
      while (cyc != k * 1000 && guard < 20000) begin
        @(negedge clk_in);
        guard++;
      end
      check("pulse_wait", 384'(guard < 20000), 384'(1));
      check("pulse_valid", 384'(row_valid_out), 384'(1));
      on_cnt = 0;
      mixed = 1'b0;
      for (int s = 0; s < 256; s++) begin
        if (row_out === {384{1'b1}}) on_cnt++;
        else if (row_out !== '0) mixed = 1'b1;
        @(negedge clk_in);
      end
      check("pulse_on_count", 384'(on_cnt), 384'(k));
      check("pulse_uniform", 384'(mixed), 384'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
